// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the RV32I pipeline hazard
// controller (pipe_hazard_ctrl) and its shadow scoreboard (haz_scoreboard).
//   RF_IDX_W / FW_SEL_W : register index and forwarding-select widths
//   FW_FROM_*           : EX operand source encodings
//   haz_state_e         : controller FSM states
//   sb_dbg_t            : debug view of the shadow scoreboard
package pipe_ctrl_pkg;

  localparam int RF_IDX_W = 5;
  localparam int FW_SEL_W = 2;

  localparam logic [FW_SEL_W-1:0] FW_FROM_ID  = 2'd0;
  localparam logic [FW_SEL_W-1:0] FW_FROM_MEM = 2'd1;
  localparam logic [FW_SEL_W-1:0] FW_FROM_WB  = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } haz_state_e;

  typedef struct packed {
    logic [RF_IDX_W-1:0] ex_rd;
    logic                ex_ld;
    logic [RF_IDX_W-1:0] mem_rd;
    logic [RF_IDX_W-1:0] wb_rd;
  } sb_dbg_t;

  // A source depends on a producer only if it is actually read and is not x0.
  function automatic logic src_match(input logic                use_f,
                                     input logic [RF_IDX_W-1:0] src,
                                     input logic [RF_IDX_W-1:0] dst);
    return use_f && (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the pipeline datapath and the hazard
// controller.
//   ID decode info : id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1,
//                    id_uses_rs2, id_rd_idx, id_is_load
//   EX / memory    : ex_br_taken, im_wait, dm_wait
//   Controls       : stall_if, stall_id, bubble_ex, flush_id, freeze,
//                    fw_rs1_sel, fw_rs2_sel
//   Debug          : state (FSM state), sb_dbg (shadow scoreboard contents)
// Handshake: there is no valid/ready pair here; every control is a level
// that applies to the clock edge that ends the current cycle, and the
// datapath must obey it in that same cycle.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                id_valid;
  logic [RF_IDX_W-1:0] id_rs1_idx;
  logic [RF_IDX_W-1:0] id_rs2_idx;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [RF_IDX_W-1:0] id_rd_idx;
  logic                id_is_load;
  logic                ex_br_taken;
  logic                im_wait;
  logic                dm_wait;

  logic                stall_if;
  logic                stall_id;
  logic                bubble_ex;
  logic                flush_id;
  logic                freeze;
  logic [FW_SEL_W-1:0] fw_rs1_sel;
  logic [FW_SEL_W-1:0] fw_rs2_sel;

  haz_state_e          state;
  sb_dbg_t             sb_dbg;

  modport master (
    output id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           id_rd_idx, id_is_load, ex_br_taken, im_wait, dm_wait,
    input  stall_if, stall_id, bubble_ex, flush_id, freeze,
           fw_rs1_sel, fw_rs2_sel, state, sb_dbg
  );

  modport slave (
    input  id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           id_rd_idx, id_is_load, ex_br_taken, im_wait, dm_wait,
    output stall_if, stall_id, bubble_ex, flush_id, freeze,
           fw_rs1_sel, fw_rs2_sel, state, sb_dbg
  );

endinterface

// File: rtl/haz_scoreboard.sv
// haz_scoreboard: shadow copy of the destination registers in EX, MEM and WB
// plus the EX load flag, and the ID-source match logic against them.
//   clk, rst        : clock, synchronous active-high reset
//   advance_i       : pipeline moves this cycle (not frozen)
//   ex_load_i       : a real instruction enters EX (else a bubble does)
//   id_*_i          : ID decode fields
//   ex_hit1/2_o     : ID rs1/rs2 matches the EX producer
//   mem_hit1/2_o    : ID rs1/rs2 matches the MEM producer
//   ex_ld_o         : EX producer is a load
//   sb_dbg_o        : scoreboard contents
module haz_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                advance_i,
  input  logic                ex_load_i,
  input  logic [RF_IDX_W-1:0] id_rd_idx_i,
  input  logic                id_is_load_i,
  input  logic [RF_IDX_W-1:0] id_rs1_idx_i,
  input  logic [RF_IDX_W-1:0] id_rs2_idx_i,
  input  logic                id_uses_rs1_i,
  input  logic                id_uses_rs2_i,
  output logic                ex_hit1_o,
  output logic                ex_hit2_o,
  output logic                mem_hit1_o,
  output logic                mem_hit2_o,
  output logic                ex_ld_o,
  output sb_dbg_t             sb_dbg_o
);

  logic [RF_IDX_W-1:0] ex_rd_q, ex_rd_d;
  logic                ex_ld_q, ex_ld_d;
  logic [RF_IDX_W-1:0] mem_rd_q, mem_rd_d;
  logic [RF_IDX_W-1:0] wb_rd_q, wb_rd_d;

  always_comb begin
    ex_rd_d  = ex_rd_q;
    ex_ld_d  = ex_ld_q;
    mem_rd_d = mem_rd_q;
    wb_rd_d  = wb_rd_q;
    if (advance_i) begin
      wb_rd_d  = mem_rd_q;
      mem_rd_d = ex_rd_q;
      ex_rd_d  = ex_load_i ? id_rd_idx_i : '0;
      ex_ld_d  = ex_load_i && id_is_load_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd_q  <= '0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // WB producers are never matched: the register file writes through, so ID
  // already reads the new value in that cycle.
  assign ex_hit1_o  = src_match(id_uses_rs1_i, id_rs1_idx_i, ex_rd_q);
  assign ex_hit2_o  = src_match(id_uses_rs2_i, id_rs2_idx_i, ex_rd_q);
  assign mem_hit1_o = src_match(id_uses_rs1_i, id_rs1_idx_i, mem_rd_q);
  assign mem_hit2_o = src_match(id_uses_rs2_i, id_rs2_idx_i, mem_rd_q);
  assign ex_ld_o    = ex_ld_q;

  assign sb_dbg_o = '{ex_rd: ex_rd_q, ex_ld: ex_ld_q, mem_rd: mem_rd_q, wb_rd: wb_rd_q};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage RV32I
// pipeline. Produces load-use stalls, taken-branch flushes, memory-wait
// freezes and registered EX forwarding selects.
//   clk, rst : clock, synchronous active-high reset (dominates everything)
//   hz       : pipe_hazard_ctrl_if.slave (decode info in, controls out,
//              FSM state and scoreboard debug out)
// Optional build macro HAZ_PERF_CNT_EN adds saturating 32-bit counters
//   cnt_lu_stall, cnt_flush, cnt_freeze as output ports.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  pipe_hazard_ctrl_if.slave        hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]              cnt_lu_stall,
  output logic [31:0]              cnt_flush,
  output logic [31:0]              cnt_freeze
`endif
);

  haz_state_e state_q, state_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, ex_ld;
  logic wait_w, lu_w;
  logic stall_if_c, stall_id_c, bubble_c, flush_c, freeze_c, lu_evt_c;

  logic [FW_SEL_W-1:0] fw1_q, fw1_d, fw2_q, fw2_d;
  sb_dbg_t             sb_dbg;

  haz_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .advance_i    (!freeze_c),
    .ex_load_i    (hz.id_valid && !bubble_c),
    .id_rd_idx_i  (hz.id_rd_idx),
    .id_is_load_i (hz.id_is_load),
    .id_rs1_idx_i (hz.id_rs1_idx),
    .id_rs2_idx_i (hz.id_rs2_idx),
    .id_uses_rs1_i(hz.id_uses_rs1),
    .id_uses_rs2_i(hz.id_uses_rs2),
    .ex_hit1_o    (ex_hit1),
    .ex_hit2_o    (ex_hit2),
    .mem_hit1_o   (mem_hit1),
    .mem_hit2_o   (mem_hit2),
    .ex_ld_o      (ex_ld),
    .sb_dbg_o     (sb_dbg)
  );

  assign wait_w = hz.im_wait || hz.dm_wait;
  // ex_hit already excludes x0 and unused sources.
  assign lu_w   = hz.id_valid && ex_ld && (ex_hit1 || ex_hit2);

  // Freeze is a pure function of the wait lines in every state, so the
  // freeze window matches the wait window cycle for cycle; FREEZE merely
  // records that the pipe was held. A taken branch held in EX during a
  // freeze is acted on in the first cycle after release.
  always_comb begin
    state_d    = RUN;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    freeze_c   = 1'b0;
    lu_evt_c   = 1'b0;
    if (!rst) begin
      if (wait_w) begin
        freeze_c   = 1'b1;
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        state_d    = FREEZE;
      end else if (state_q == FLUSH) begin
        state_d = RUN;
      end else if (hz.ex_br_taken) begin
        // The ID instruction is squashed, so its load-use hazard is moot.
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        state_d  = FLUSH;
      end else if (lu_w) begin
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        bubble_c   = 1'b1;
        lu_evt_c   = 1'b1;
      end
    end
  end

  // Selects are computed against the producers one stage ahead of where the
  // consumer will sit next cycle: EX producer -> MEM forward, MEM -> WB.
  always_comb begin
    fw1_d = FW_FROM_ID;
    fw2_d = FW_FROM_ID;
    if (hz.id_valid && !bubble_c) begin
      if (ex_hit1)       fw1_d = FW_FROM_MEM;
      else if (mem_hit1) fw1_d = FW_FROM_WB;
      if (ex_hit2)       fw2_d = FW_FROM_MEM;
      else if (mem_hit2) fw2_d = FW_FROM_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fw1_q   <= FW_FROM_ID;
      fw2_q   <= FW_FROM_ID;
    end else begin
      state_q <= state_d;
      if (!freeze_c) begin
        fw1_q <= fw1_d;
        fw2_q <= fw2_d;
      end
    end
  end

  assign hz.stall_if   = stall_if_c;
  assign hz.stall_id   = stall_id_c;
  assign hz.bubble_ex  = bubble_c;
  assign hz.flush_id   = flush_c;
  assign hz.freeze     = freeze_c;
  assign hz.fw_rs1_sel = fw1_q;
  assign hz.fw_rs2_sel = fw2_q;
  assign hz.state      = state_q;
  assign hz.sb_dbg     = sb_dbg;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_stall <= '0;
      cnt_flush    <= '0;
      cnt_freeze   <= '0;
    end else begin
      if (lu_evt_c && (cnt_lu_stall != '1)) cnt_lu_stall <= cnt_lu_stall + 32'd1;
      if (flush_c  && (cnt_flush    != '1)) cnt_flush    <= cnt_flush + 32'd1;
      if (freeze_c && (cnt_freeze   != '1)) cnt_freeze   <= cnt_freeze + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: self-checking bench for pipe_hazard_ctrl.
// Build with HAZ_PERF_CNT_EN defined to also exercise the perf counters.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] c_lu, c_fl, c_fz;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
`ifdef HAZ_PERF_CNT_EN
    ,
    .cnt_lu_stall(c_lu),
    .cnt_flush   (c_fl),
    .cnt_freeze  (c_fz)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  exp_q[$];          // expected {fw_rs1_sel, fw_rs2_sel}
  haz_state_e  m_state;
  logic [4:0]  m_ex_rd, m_mem_rd, m_wb_rd;
  logic        m_ex_ld;
  logic [4:0]  last_ctrl;         // {stall_if, stall_id, bubble_ex, flush_id, freeze}
  logic [1:0]  last_state;
  int          freeze_cnt = 0;
  sb_dbg_t     sb_snap;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
  endtask

  function automatic logic dep(input logic u, input logic [4:0] s, input logic [4:0] d);
    return u && (s != 5'd0) && (s == d);
  endfunction

  function automatic logic [1:0] fsel(input logic u, input logic [4:0] s);
    if (dep(u, s, m_ex_rd))  return 2'd1;
    if (dep(u, s, m_mem_rd)) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- driver ----------------
  // One pipeline cycle: drive ID/EX/memory inputs, check the cycle's
  // controls at the negedge, then advance the reference model at the edge.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic br, input logic imw, input logic dmw);
    logic [4:0] e_ctrl;
    haz_state_e e_next;
    logic [3:0] fw_prev;
    logic [3:0] fw_new;
    logic       lu;
    hz.id_valid    = v;
    hz.id_rs1_idx  = rs1;
    hz.id_rs2_idx  = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;
    hz.id_rd_idx   = rd;
    hz.id_is_load  = ld;
    hz.ex_br_taken = br;
    hz.im_wait     = imw;
    hz.dm_wait     = dmw;

    lu     = v && m_ex_ld && (dep(u1, rs1, m_ex_rd) || dep(u2, rs2, m_ex_rd));
    e_ctrl = 5'b00000;
    e_next = RUN;
    if (rst)                    e_next = RUN;
    else if (imw || dmw) begin  e_ctrl = 5'b11001; e_next = FREEZE; end
    else if (m_state == FLUSH)  e_next = RUN;
    else if (br) begin          e_ctrl = 5'b00110; e_next = FLUSH; end
    else if (lu)                e_ctrl = 5'b11100;

    @(negedge clk);
    last_ctrl  = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id, hz.freeze};
    last_state = hz.state;
    check("ctrl", 32'(last_ctrl), 32'(e_ctrl));
    check("state", 32'(last_state), 32'(m_state));
    check("sb", 32'(hz.sb_dbg), 32'({m_ex_rd, m_ex_ld, m_mem_rd, m_wb_rd}));
    if (exp_q.size() == 0) begin
      check("fw_queue_empty", 32'd0, 32'd1);
      fw_prev = 4'd0;
    end else begin
      fw_prev = exp_q.pop_front();
      check("fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'(fw_prev));
    end
    if (last_ctrl[0]) freeze_cnt++;

    @(posedge clk);
    #1;
    if (rst) begin
      m_state = RUN; m_ex_rd = '0; m_ex_ld = 1'b0; m_mem_rd = '0; m_wb_rd = '0;
      exp_q.push_back(4'd0);
    end else begin
      if (!e_ctrl[0]) begin
        fw_new   = (e_ctrl[2] || !v) ? 4'd0 : {fsel(u1, rs1), fsel(u2, rs2)};
        m_wb_rd  = m_mem_rd;
        m_mem_rd = m_ex_rd;
        m_ex_rd  = (e_ctrl[2] || !v) ? 5'd0 : rd;
        m_ex_ld  = (e_ctrl[2] || !v) ? 1'b0 : ld;
        exp_q.push_back(fw_new);
      end else begin
        exp_q.push_back(fw_prev);
      end
      m_state = e_next;
    end
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic ld);
    step(1'b1, rs1, rs2, u1, u2, rd, ld, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    hz.id_valid = 0; hz.id_rs1_idx = 0; hz.id_rs2_idx = 0; hz.id_uses_rs1 = 0;
    hz.id_uses_rs2 = 0; hz.id_rd_idx = 0; hz.id_is_load = 0; hz.ex_br_taken = 0;
    hz.im_wait = 0; hz.dm_wait = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_state = RUN; m_ex_rd = '0; m_ex_ld = 1'b0; m_mem_rd = '0; m_wb_rd = '0;
    exp_q.push_back(4'd0);
    rst = 1'b0;

    // reset state
    idle();
    check("rst_ctrl", 32'(last_ctrl), 32'd0);
    check("rst_state", 32'(last_state), 32'(RUN));
`ifdef HAZ_PERF_CNT_EN
    check("rst_cnt", c_lu | c_fl | c_fz, 32'd0);
`endif

    // LD x5 ; ADD x6,x5,x1 -> one stall cycle, then rs1 forwarded from WB
    ins(5'd1, 5'd0, 1, 0, 5'd5, 1);
    ins(5'd5, 5'd1, 1, 1, 5'd6, 0);
    check("lu_stall", 32'(last_ctrl), 32'b11100);
    ins(5'd5, 5'd1, 1, 1, 5'd6, 0);
    check("lu_no_stall", 32'(last_ctrl), 32'd0);
    check("lu_fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'(4'b1000));
    idle(); idle();

    // ADD x3 ; SUB x4,x3,x3 -> both from MEM
    ins(5'd1, 5'd2, 1, 1, 5'd3, 0);
    ins(5'd3, 5'd3, 1, 1, 5'd4, 0);
    check("raw1_fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'(4'b0101));
    check("raw1_nostall", 32'(last_ctrl), 32'd0);
    // ADD x3 ; unrelated ; SUB x4,x3,x3 -> both from WB
    ins(5'd1, 5'd2, 1, 1, 5'd3, 0);
    ins(5'd1, 5'd2, 1, 1, 5'd7, 0);
    ins(5'd3, 5'd3, 1, 1, 5'd4, 0);
    check("raw2_fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'(4'b1010));

    // writes to x0 then uses of x0 never forward or stall
    ins(5'd1, 5'd2, 1, 1, 5'd0, 0);
    ins(5'd0, 5'd0, 1, 1, 5'd0, 1);
    check("x0_fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'd0);
    ins(5'd0, 5'd0, 1, 1, 5'd9, 0);
    check("x0_nostall", 32'(last_ctrl), 32'd0);
    check("x0_fw2", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'd0);

    // taken branch while ID holds a load-use consumer
    idle();
    ins(5'd1, 5'd0, 1, 0, 5'd5, 1);
    step(1, 5'd5, 5'd1, 1, 1, 5'd6, 0, 1, 0, 0);
    check("br_flush", 32'(last_ctrl), 32'b00110);
    idle();
    check("br_flush_state", 32'(last_state), 32'(FLUSH));
    check("br_flush_quiet", 32'(last_ctrl), 32'd0);
    idle();
    check("br_back_run", 32'(last_state), 32'(RUN));

    // dm_wait for 3 cycles in the middle of a load-use sequence
    ins(5'd1, 5'd0, 1, 0, 5'd5, 1);
    sb_snap    = hz.sb_dbg;
    freeze_cnt = 0;
    repeat (3) step(1, 5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 1);
    ins(5'd5, 5'd1, 1, 1, 5'd6, 0);
    check("frz_cycles", 32'(freeze_cnt), 32'd3);
    check("frz_release_lu", 32'(last_ctrl), 32'b11100);
    ins(5'd5, 5'd1, 1, 1, 5'd6, 0);
    check("frz_fw", 32'({hz.fw_rs1_sel, hz.fw_rs2_sel}), 32'(4'b1000));
    check("frz_sb_mem", 32'(hz.sb_dbg.wb_rd), 32'(sb_snap.ex_rd));

    // taken branch held through an im_wait freeze, acted on after release
    ins(5'd1, 5'd2, 1, 1, 5'd3, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
    check("br_frz", 32'(last_ctrl), 32'b11001);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    check("br_after_frz", 32'(last_ctrl), 32'b00110);
    idle(); idle();

    // random traffic against the model
    repeat (300) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0);
    end

    // reset asserted during FREEZE
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
    rst = 1'b1;
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
    check("rst_frz_quiet", 32'(last_ctrl), 32'd0);
    rst = 1'b0;
    idle();
    check("rst_frz_ctrl", 32'(last_ctrl), 32'd0);
    check("rst_frz_state", 32'(last_state), 32'(RUN));
`ifdef HAZ_PERF_CNT_EN
    check("rst_frz_cnt", c_lu | c_fl | c_fz, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Watches the instruction being decoded in ID and keeps its own shadow scoreboard of destination registers in EX, MEM and WB.
- Generates:
  - load-use stalls;
  - branch/jump flushes;
  - whole-pipe freezes on memory wait;
  - registered EX operand-forwarding selects.

Parameters:
- RF_IDX_W, 5, register index width.
- FW_SEL_W, 2, forwarding select width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1_idx  in  5  source 1 index (already 0 for LUI)
- id_rs2_idx  in  5  source 2 index
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd_idx  in  5  destination (0 for store/branch)
- id_is_load  in  1  instruction is LD
- ex_br_taken  in  1  EX resolved taken branch, JAL or JALR
- im_wait  in  1  instruction memory not ready
- dm_wait  in  1  data memory not ready
- stall_if  out  1  hold PC/IF-ID register
- stall_id  out  1  hold ID outputs
- bubble_ex  out  1  ID-EX register loads NOP (alu_op NOP, rd 0, no mem rd/wr)
- flush_id  out  1  IF-ID register loads NOP
- freeze  out  1  all pipeline registers hold
- fw_rs1_sel  out  2  EX op1 source: 0 from ID, 1 forward from MEM, 2 forward from WB
- fw_rs2_sel  out  2  same for op2

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - every output is 0; fw selects are 0 (from ID);
  - all shadow entries are rd=0, load=0;
  - state is RUN.
- Shadow scoreboard:
  - Contents: ex_rd/ex_ld, mem_rd, wb_rd.
  - Advances only when freeze=0.
  - The ex entry loads id_rd_idx/id_is_load, or 0/0 when bubble_ex=1 or id_valid=0.
- Forwarding selects:
  - Computed in ID, registered when the ID-EX register advances; 1-cycle latency, aligned with EX.
  - rs1/rs2 matching ex_rd gives sel 1, because that producer will be in MEM next cycle.
  - Otherwise a match on mem_rd gives sel 2.
  - Otherwise sel 0.
  - MEM has priority over WB.
  - Index 0 never forwards; the matching use flag must be set.
  - A producer in WB that matches ID in the same cycle is not forwarded; the register file is write-through.
- Load-use:
  - Detected when id_valid, ex_ld=1, ex_rd≠0, and a used source equals ex_rd.
  - Response: stall_if=1, stall_id=1, bubble_ex=1 for exactly 1 cycle.
  - On the following cycle the load is in MEM and ID sees it as mem_rd, so it forwards with sel 2.
- FSM states:
  - RUN
    - Normal operation.
    - Load-use → LU_STALL outputs asserted combinationally this cycle; next state is RUN.
    - Wait → FREEZE.
  - FREEZE
    - freeze=1, stall_if=1, stall_id=1; no bubble, no flush; the scoreboard holds.
    - Stays while im_wait|dm_wait.
    - Returns to RUN on the first cycle both are 0; the outputs in that cycle are re-evaluated as RUN.
  - FLUSH
    - Entered from RUN when ex_br_taken=1.
    - In that cycle: flush_id=1 and bubble_ex=1; IF is not stalled.
    - Load-use from the squashed ID instruction is ignored.
    - FLUSH lasts 1 cycle with no outputs asserted; it returns to RUN and exists only for the perf counters and the monitor.
- Priority: rst > wait/freeze > ex_br_taken > load-use.
- ex_br_taken during freeze is held by EX and acted on after the freeze releases.
- Back-to-back load-use followed by taken branch: the branch flush wins, and any pending stall is dropped.
- Mid-operation reset returns to RUN on the next edge, with no residual stall.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds three 32-bit saturating counters:
  - cnt_lu_stall, incremented on every load-use cycle;
  - cnt_flush, incremented on every branch flush;
  - cnt_freeze, incremented on every FREEZE cycle.
- Counter behaviour:
  - exposed as output ports;
  - cleared by rst;
  - saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - fw select constants FW_FROM_ID=0, FW_FROM_MEM=1, FW_FROM_WB=2;
  - state enum haz_state_e {RUN, FREEZE, FLUSH};
  - RF_IDX_W.
- One sub-module haz_scoreboard: shadow rd/load pipeline plus match logic. It outputs ex_hit1/2, mem_hit1/2 and ex_ld.

Test Plan:
- LD x5 then ADD x6,x5,x1 → one cycle of stall_if=stall_id=bubble_ex=1. ADD then enters EX with fw_rs1_sel=2; fw_rs2_sel=0.
- ADD x3,x1,x2 then SUB x4,x3,x3 → no stall; both SUB selects are 1 in EX. With one unrelated instruction in between, both selects are 2.
- Writes to x0 followed by use of x0 → selects remain 0 and no stall.
- ex_br_taken=1 while ID holds a load-use consumer → flush_id=1, bubble_ex=1 and stall_if=0 in the same cycle. The next cycle is FLUSH with all outputs 0, then RUN.
- dm_wait high for 3 cycles in the middle of the hazard sequence → freeze=1 for exactly 3 cycles, the scoreboard is unchanged, and forwarding is correct after release.
- rst asserted during FREEZE → the next cycle has all outputs 0 and state RUN. With HAZ_PERF_CNT_EN, all counters read 0.
